// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory port among NREQ kernels
// One transaction in flight; a watchdog aborts a stuck memory access with ERR_DATA.
module mem_bus_arbiter #(
  parameter int          NREQ     = 2,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      s_valid,
  input  logic [NREQ-1:0]      s_write,
  input  logic [3*NREQ-1:0]    s_size,
  input  logic [32*NREQ-1:0]   s_addr,
  input  logic [32*NREQ-1:0]   s_wdata,
  output logic [NREQ-1:0]      s_ready,
  output logic [31:0]          s_rdata,
  output logic                 m_valid,
  output logic                 m_write,
  output logic [2:0]           m_size,
  output logic [31:0]          m_addr,
  output logic [31:0]          m_wdata,
  input  logic [31:0]          m_rdata,
  input  logic                 m_ready,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           err_id,
  input  logic                 err_clr
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              m_valid_q, m_valid_d;
  logic              m_write_q, m_write_d;
  logic [2:0]        m_size_q, m_size_d;
  logic [31:0]       m_addr_q, m_addr_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [NREQ-1:0]   s_ready_q, s_ready_d;
  logic [31:0]       s_rdata_q, s_rdata_d;
  logic              err_q, err_d;
  logic [1:0]        err_id_q, err_id_d;
  logic [WDW-1:0]    wd_cnt_q, wd_cnt_d;

  logic              win_found;
  logic [1:0]        win_idx;
  logic [NREQ-1:0]   win_oh;
  logic              sel_write;
  logic [2:0]        sel_size;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;

  // Two descending passes: requesters at or below rr_ptr are the wrap-around
  // fallback, requesters above rr_ptr override them; lowest index wins per pass.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    win_oh    = '0;
    for (int c = NREQ - 1; c >= 0; c--) begin
      if (s_valid[c] && (2'(c) <= rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = 2'(c);
        win_oh    = '0;
        win_oh[c] = 1'b1;
      end
    end
    for (int c = NREQ - 1; c >= 0; c--) begin
      if (s_valid[c] && (2'(c) > rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = 2'(c);
        win_oh    = '0;
        win_oh[c] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_write = 1'b0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int c = 0; c < NREQ; c++) begin
      if (win_oh[c]) begin
        sel_write = s_write[c];
        sel_size  = s_size[3*c +: 3];
        sel_addr  = s_addr[32*c +: 32];
        sel_wdata = s_wdata[32*c +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    m_valid_d = m_valid_q;
    m_write_d = m_write_q;
    m_size_d  = m_size_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    s_ready_d = s_ready_q;
    s_rdata_d = s_rdata_q;
    err_d     = err_clr ? 1'b0 : err_q;
    err_id_d  = err_id_q;
    wd_cnt_d  = wd_cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = BUSY;
          grant_d   = win_oh;
          rr_ptr_d  = win_idx;
          m_valid_d = 1'b1;
          m_write_d = sel_write;
          m_size_d  = sel_size;
          m_addr_d  = sel_addr;
          m_wdata_d = sel_wdata;
          wd_cnt_d  = '0;
        end
      end
      BUSY: begin
        if (m_ready) begin
          state_d   = DONE;
          m_valid_d = 1'b0;
          s_ready_d = grant_q;
          if (!m_write_q) s_rdata_d = m_rdata;
        end else if ((TIMEOUT != 0) && (wd_cnt_q == WD_LAST)) begin
          // rr_ptr still names the owner of the transaction being aborted
          state_d   = DONE;
          m_valid_d = 1'b0;
          s_ready_d = grant_q;
          s_rdata_d = ERR_DATA;
          err_d     = 1'b1;
          err_id_d  = rr_ptr_q;
        end else begin
          wd_cnt_d = wd_cnt_q + WDW'(1);
        end
      end
      DONE: begin
        state_d   = IDLE;
        s_ready_d = '0;
        grant_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 2'(NREQ - 1);
      grant_q   <= '0;
      m_valid_q <= 1'b0;
      m_write_q <= 1'b0;
      m_size_q  <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      s_ready_q <= '0;
      s_rdata_q <= '0;
      err_q     <= 1'b0;
      err_id_q  <= '0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_write_q <= m_write_d;
      m_size_q  <= m_size_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      s_ready_q <= s_ready_d;
      s_rdata_q <= s_rdata_d;
      err_q     <= err_d;
      err_id_q  <= err_id_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  assign s_ready = s_ready_q;
  assign s_rdata = s_rdata_q;
  assign m_valid = m_valid_q;
  assign m_write = m_write_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign err     = err_q;
  assign err_id  = err_id_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with a transaction-level model
module tb_mem_bus_arbiter;
  localparam int          NREQ     = 4;
  localparam int          TIMEOUT  = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic [NREQ-1:0]     s_valid = '0, s_write = '0;
  logic [3*NREQ-1:0]   s_size = '0;
  logic [32*NREQ-1:0]  s_addr = '0, s_wdata = '0;
  logic [NREQ-1:0]     s_ready, grant;
  logic [31:0]         s_rdata, m_addr, m_wdata;
  logic                m_valid, m_write, busy, err;
  logic [2:0]          m_size;
  logic [1:0]          err_id;
  logic [31:0]         m_rdata = '0;
  logic                m_ready = 1'b0, err_clr = 1'b0;

  mem_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_write(s_write), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .m_valid(m_valid), .m_write(m_write), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .grant(grant), .busy(busy), .err(err), .err_id(err_id), .err_clr(err_clr)
  );

  typedef struct { int idx; logic [31:0] addr; logic [2:0] size; logic wr; logic [31:0] wdata; } req_t;
  typedef struct { int idx; logic [31:0] rdata; int due; } rsp_t;
  typedef struct { logic e; logic [1:0] id; } errx_t;

  req_t  req_q[$];
  rsp_t  rsp_q[$];
  errx_t err_exp_q[$];

  int vectors = 0, miscompares = 0;

  // requester-side state
  logic [31:0] r_addr[NREQ], r_wdata[NREQ];
  logic [2:0]  r_size[NREQ];
  logic        r_write[NREQ];
  int          pend[NREQ];
  bit          fix_en[NREQ];
  logic [31:0] fix_addr[NREQ], fix_wdata[NREQ];
  logic [2:0]  fix_size[NREQ];
  logic        fix_write[NREQ];

  // reference model and controls
  int          ref_last = NREQ - 1;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  logic [1:0]  exp_err_id = '0;
  int          kbusy = 0, wcur = 0, cur_idx = 0, cyc = 0;
  logic        cur_wr = 1'b0, mv_prev = 1'b0;
  int          mem_wait_fix = -1, clr_mode = 0;
  bit          rst_req = 1, rst_arm = 0, rand_gap = 0, fix_rdata_en = 0, mon_en = 0;
  logic [31:0] fix_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] sv);
    for (int i = 1; i <= NREQ; i++) begin
      int c;
      c = (ref_last + i) % NREQ;
      if (sv[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      s_addr[32*k +: 32]  = r_addr[k];
      s_wdata[32*k +: 32] = r_wdata[k];
      s_size[3*k +: 3]    = r_size[k];
      s_write[k]          = r_write[k];
    end
  endtask

  task automatic step();
    bit timeout_now;
    @(negedge clk);
    cyc++;
    timeout_now = 0;
    if (m_valid) begin
      kbusy = mv_prev ? kbusy + 1 : 0;
      if (kbusy == 0) begin
        cur_idx = rr_pick(s_valid);
        if (cur_idx >= 0) begin
          ref_last = cur_idx;
          cur_wr   = r_write[cur_idx];
          req_q.push_back('{cur_idx, r_addr[cur_idx], r_size[cur_idx], r_write[cur_idx], r_wdata[cur_idx]});
        end else begin
          cur_wr = 1'b1;
          req_q.push_back('{-1, 32'h0, 3'h0, 1'b0, 32'h0});
        end
        if (mem_wait_fix >= 0) wcur = mem_wait_fix;
        else begin
          int r;
          r = int'($urandom % 12);
          wcur = (r == 0) ? 99 : r % 4;
        end
      end
    end
    mv_prev = m_valid;

    if (rst_req || (rst_arm && m_valid && kbusy == 1)) begin
      rst = 1'b1;
      rst_arm = 0;
      ref_last = NREQ - 1;
      exp_rdata = '0;
      exp_err = 1'b0;
      exp_err_id = '0;
      mv_prev = 1'b0;
      m_ready = 1'b0;
      err_clr = 1'b0;
      s_valid = '0;
      for (int k = 0; k < NREQ; k++) pend[k] = 0;
      req_q.delete();
      rsp_q.delete();
      err_exp_q.push_back('{1'b0, 2'b00});
      drive();
      return;
    end
    rst = 1'b0;

    m_rdata = $urandom;
    m_ready = 1'b0;
    if (m_valid && kbusy == wcur && wcur < TIMEOUT) begin
      m_ready = 1'b1;
      if (fix_rdata_en) m_rdata = fix_rdata;
      if (!cur_wr) exp_rdata = m_rdata;
      rsp_q.push_back('{cur_idx, exp_rdata, cyc + 1});
    end else if (m_valid && kbusy == TIMEOUT - 1) begin
      timeout_now = 1;
      exp_rdata = ERR_DATA;
      rsp_q.push_back('{cur_idx, exp_rdata, cyc + 1});
    end else if (!m_valid) begin
      m_ready = 1'($urandom % 2);
    end

    err_clr = (clr_mode >= 0) ? 1'(clr_mode) : 1'($urandom % 8 == 0);
    if (timeout_now) begin
      exp_err = 1'b1;
      exp_err_id = cur_idx[1:0];
    end else if (err_clr) begin
      exp_err = 1'b0;
    end
    err_exp_q.push_back('{exp_err, exp_err_id});

    for (int k = 0; k < NREQ; k++) begin
      if (s_valid[k] && s_ready[k]) begin
        s_valid[k] = 1'b0;
      end else if (!s_valid[k] && pend[k] > 0 && (!rand_gap || $urandom % 3 == 0)) begin
        if (fix_en[k]) begin
          r_addr[k] = fix_addr[k]; r_size[k] = fix_size[k];
          r_write[k] = fix_write[k]; r_wdata[k] = fix_wdata[k];
        end else begin
          r_addr[k] = $urandom; r_size[k] = 3'($urandom % 3);
          r_write[k] = 1'($urandom % 2); r_wdata[k] = $urandom;
        end
        s_valid[k] = 1'b1;
        pend[k]--;
      end
    end
    drive();
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      int p;
      p = 0;
      for (int k = 0; k < NREQ; k++) p += pend[k];
      if (p == 0 && s_valid == '0 && !busy && rsp_q.size() == 0) done = 1;
      else step();
    end
    step();
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got busy=%0b pending_rsp=%0d required idle", busy, rsp_q.size());
    end
  endtask

  // monitor / scoreboard
  logic            p_rst = 1'b1, p_busy = 1'b0, p_mv = 1'b0;
  logic [NREQ-1:0] p_sv = '0, p_sready = '0;
  logic [31:0]     p_rdata = '0, p_addr = '0, p_wdata = '0;
  logic [2:0]      p_size = '0;
  logic            p_write = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (err_exp_q.size() >= 2) begin
        errx_t e;
        e = err_exp_q.pop_front();
        check("err_state", {61'b0, err, err_id}, {61'b0, e.e, e.id});
      end
      if (p_rst) begin
        check("reset_outputs", {18'b0, m_valid, grant, s_ready, busy, m_write, m_size, s_rdata}, 64'h0);
        check("reset_maddr", {m_addr, m_wdata}, 64'h0);
      end else begin
        check("busy_flag", {63'b0, busy}, {63'b0, (m_valid || (s_ready != '0))});
        check("ready_isolation", {31'b0, ($countones(s_ready) > 1), (s_ready & ~grant)},
              64'h0);
        if (!p_busy) check("grant_start", {63'b0, m_valid}, {63'b0, (p_sv != '0)});
        if (m_valid && !p_mv) begin
          if (req_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_grant: got grant=%b required no transaction", grant);
          end else begin
            req_t r;
            logic [NREQ-1:0] eg;
            r = req_q.pop_front();
            eg = '0;
            if (r.idx >= 0) eg[r.idx] = 1'b1;
            check("grant_owner", {60'b0, grant}, {60'b0, eg});
            check("m_addr_wdata", {m_addr, m_wdata}, {r.addr, r.wdata});
            check("m_size_write", {60'b0, m_size, m_write}, {60'b0, r.size, r.wr});
          end
        end else if (m_valid) begin
          check("m_hold", {m_addr, m_wdata}, {p_addr, p_wdata});
          check("m_hold_ctl", {60'b0, m_size, m_write}, {60'b0, p_size, p_write});
        end
        if (s_ready != '0) begin
          if (rsp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_ready: got s_ready=%b required none", s_ready);
          end else begin
            rsp_t x;
            logic [NREQ-1:0] er;
            x = rsp_q.pop_front();
            er = '0;
            if (x.idx >= 0) er[x.idx] = 1'b1;
            check("ready_owner", {60'b0, s_ready}, {60'b0, er});
            check("s_rdata", {32'b0, s_rdata}, {32'b0, x.rdata});
            check("ready_cycle", 64'(cyc), 64'(x.due));
          end
        end else begin
          check("rdata_stable", {32'b0, s_rdata}, {32'b0, p_rdata});
        end
        if (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
          vectors++; miscompares++;
          $display("FAIL ready_missing: got no s_ready by cycle %0d required at %0d", cyc, rsp_q[0].due);
          void'(rsp_q.pop_front());
        end
        if (p_sready != '0) check("done_exit", {55'b0, grant, s_ready, m_valid}, 64'h0);
      end
    end
    p_rst = rst; p_busy = busy; p_mv = m_valid; p_sv = s_valid; p_sready = s_ready;
    p_rdata = s_rdata; p_addr = m_addr; p_wdata = m_wdata; p_size = m_size; p_write = m_write;
  end

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      r_addr[k] = '0; r_wdata[k] = '0; r_size[k] = '0; r_write[k] = 1'b0;
      pend[k] = 0; fix_en[k] = 0;
      fix_addr[k] = '0; fix_wdata[k] = '0; fix_size[k] = '0; fix_write[k] = 1'b0;
    end
    rst_req = 1;
    step();
    step();
    rst_req = 0;
    mon_en = 1;

    // single read with two wait states
    fix_en[0] = 1; fix_addr[0] = 32'h100; fix_size[0] = 3'd2; fix_write[0] = 1'b0;
    fix_rdata_en = 1; fix_rdata = 32'h12345678; mem_wait_fix = 2;
    pend[0] = 1;
    wait_idle();
    fix_en[0] = 0; fix_rdata_en = 0;

    // contention, zero-wait memory
    mem_wait_fix = 0;
    pend[0] = 4; pend[1] = 4;
    wait_idle();

    // byte write from requester 1
    fix_en[1] = 1; fix_addr[1] = 32'h103; fix_size[1] = 3'd0; fix_write[1] = 1'b1;
    fix_wdata[1] = 32'h000000AB; mem_wait_fix = 1;
    pend[1] = 1;
    wait_idle();
    fix_en[1] = 0;

    // timeout, then clear, then ready on the last allowed cycle
    mem_wait_fix = 99;
    pend[2] = 1;
    wait_idle();
    clr_mode = 1; step();
    clr_mode = 0; step();
    mem_wait_fix = 7;
    pend[3] = 1;
    wait_idle();

    // timeout coinciding with err_clr
    mem_wait_fix = 99; clr_mode = 1;
    pend[1] = 1;
    wait_idle();
    clr_mode = 0;

    // reset in the second BUSY cycle of requester 0, then 0 and 1 together
    mem_wait_fix = 99;
    pend[0] = 1;
    rst_arm = 1;
    for (int i = 0; i < 40 && rst_arm; i++) step();
    if (rst_arm) begin
      vectors++; miscompares++;
      $display("FAIL reset_window: got no second BUSY cycle required one");
      rst_arm = 0;
    end
    step();
    step();
    mem_wait_fix = 0;
    pend[0] = 1; pend[1] = 1;
    wait_idle();

    // fairness with 0, 2 and 3 contending
    pend[0] = 3; pend[2] = 3; pend[3] = 3;
    wait_idle();

    // randomized traffic
    rand_gap = 1; mem_wait_fix = -1; clr_mode = -1;
    for (int round = 0; round < 6; round++) begin
      for (int k = 0; k < NREQ; k++) pend[k] = int'($urandom % 7);
      for (int i = 0; i < 250; i++) step();
      wait_idle();
    end
    clr_mode = 0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one 32-bit memory port (addr/size/valid/write/wdata/rdata/ready) between NREQ generated compute kernels; each kernel port follows the kernel's native handshake.
- Each kernel holds valid and its request fields stable until it sees ready, then drops valid on the next edge.
- The arbiter grants requesters round-robin, one transaction at a time, registers the request onto the memory side and returns a one-cycle ready pulse to the winner.
- A watchdog aborts transactions on a stuck memory.

Parameters:
- NREQ, 2: number of requesters; legal range 2..4.
- TIMEOUT, 255: maximum cycles to wait for m_ready; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF: value returned on s_rdata for an aborted transaction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  NREQ  per-requester request.
- s_write  in  NREQ  per-requester 1=write, 0=read.
- s_size  in  3*NREQ  per-requester size: 0=byte, 1=half, 2=word. Requester k uses bits [3k+2:3k].
- s_addr  in  32*NREQ  per-requester byte address. Requester k uses bits [32k+31:32k].
- s_wdata  in  32*NREQ  per-requester write data, same slicing as s_addr.
- s_ready  out  NREQ  per-requester completion pulse.
- s_rdata  out  32  read data, broadcast to all requesters. It is the raw word; requesters do their own lane shift.
- m_valid  out  1  memory request.
- m_write  out  1  memory write.
- m_size  out  3  memory size.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data; valid in the m_ready cycle.
- m_ready  in  1  memory completion; ignored unless m_valid=1.
- grant  out  NREQ  one-hot owner of the current transaction; 0 when IDLE.
- busy  out  1  state != IDLE.
- err  out  1  sticky timeout flag.
- err_id  out  2  requester index of the last timed-out transaction.
- err_clr  in  1  clears err. If a new timeout occurs in the same cycle, the timeout wins.

Behaviour:
- Reset values (all outputs and state):
  - state=IDLE, m_valid=0, m_write=0, m_size=0, m_addr=0, m_wdata=0.
  - s_ready=0, s_rdata=0, grant=0, err=0, err_id=0.
  - rr_ptr=NREQ-1, so requester 0 wins first.
  - wd_cnt=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any s_valid is set, the winner is the first set bit searching upward from rr_ptr+1 (mod NREQ).
  - Next edge: grant=onehot(winner), rr_ptr=winner, m_valid=1, and m_addr/m_size/m_write/m_wdata latch the winner's fields. wd_cnt=0. Go to BUSY.
  - If no s_valid is set, stay in IDLE.
- BUSY:
  - m_fields are held constant while m_valid=1.
  - On m_ready=1: m_valid<=0; s_rdata<=m_rdata on reads, unchanged on writes; s_ready[winner]<=1; go to DONE.
  - Otherwise wd_cnt increments.
  - If TIMEOUT!=0 and wd_cnt==TIMEOUT-1 without m_ready: m_valid<=0, s_rdata<=ERR_DATA, s_ready[winner]<=1, err<=1, err_id<=winner, go to DONE.
  - If m_ready arrives on that same cycle, m_ready wins and no error is raised.
- DONE (exactly one cycle):
  - s_ready[winner]=1.
  - Next edge: s_ready<=0, grant<=0, go to IDLE.
  - The requester drops s_valid on that same edge, so it is never re-granted for the completed request.
- Timing:
  - Minimum latency from s_valid rise to s_ready: 3 cycles, with m_ready asserted combinationally in the first BUSY cycle.
  - Back-to-back transactions: new grant every 3 cycles.
- Isolation and stability:
  - s_ready bits of non-winners stay 0 at all times; at most one s_ready bit is high.
  - s_rdata changes only on the edge entering DONE.
- Fairness: a requester that keeps requesting continuously waits at most NREQ-1 other transactions.
- s_valid deasserting while the requester is not granted is legal and is ignored.
- rst during BUSY or DONE:
  - The transaction is abandoned and m_valid drops at that edge.
  - No s_ready pulse is produced.
  - All state returns to reset values.

Test Plan:
- Single read: s_valid[0]=1, s_addr=0x100, size=2, memory returns 0x12345678 after 2 wait cycles.
  - Expect m_addr=0x100 and m_valid held for 3 cycles.
  - Expect s_rdata=0x12345678 together with a one-cycle s_ready[0]; s_ready[1] stays 0.
- Contention: s_valid=2'b11 continuously with zero-wait memory.
  - Expect grant sequence 01,10,01,10 with a new grant every 3 cycles.
  - Each requester's write data appears on m_wdata only while it holds the grant.
- Byte write: requester 1 sends write, size=0, addr=0x103, wdata=0x000000AB.
  - Expect m_write=1, m_size=0, m_addr=0x103.
  - Expect s_rdata unchanged after completion.
- Timeout: TIMEOUT=8, m_ready held low.
  - m_valid drops after 8 BUSY cycles.
  - s_ready pulses with s_rdata=0xDEADBEEF; err=1, err_id=requester index.
  - err_clr=1 clears err.
  - A repeat case with m_ready on the 8th cycle shows err stays 0.
- Reset mid-transaction: assert rst in the 2nd BUSY cycle.
  - Next cycle: m_valid=0, grant=0, no s_ready pulse.
  - A request after reset is granted to requester 0 first.
- Fairness, NREQ=4: requests from 0, 2 and 3 held high.
  - Expect grant order 0,2,3,0,2,3; requester 1 is never granted.
